// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory read port, redirect input and instruction output handshake.
// master = fetch unit, slave = memory / processor side.
interface instruction_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rdy;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] instruction;
    logic [31:0] inst_pc;

    modport master (
        output imem_req, imem_addr, inst_valid, instruction, inst_pc,
        input  imem_rdy, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
    );
    modport slave (
        input  imem_req, imem_addr, inst_valid, instruction, inst_pc,
        output imem_rdy, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: credit-limited word reads into an in-order prefetch FIFO, with redirect flush.
// Optional IFU_PERF_CNT_EN adds the fetch_count output (instructions popped since reset).
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    instruction_fetch_unit_if.master  bus
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]               fetch_count
`endif
);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
    } entry_t;

    entry_t [BUF_DEPTH-1:0] fifo;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, outstanding, discard;
    logic [31:0]   fetch_pc, resp_pc;
    logic [CW:0]   credit_used;
    logic          issue, push, pop;

    // Credit covers both buffered and in-flight words so returns never overflow the FIFO.
    always_comb begin
        credit_used        = {1'b0, outstanding} + {1'b0, count};
        bus.imem_req       = !rst && !bus.redirect_valid && (credit_used < (CW+1)'(BUF_DEPTH));
        bus.imem_addr      = fetch_pc;
        issue              = bus.imem_req && bus.imem_rdy;
        push               = bus.imem_rvalid && (discard == '0) && !bus.redirect_valid;
        bus.inst_valid     = (count != '0);
        pop                = bus.inst_valid && bus.inst_ready && !bus.redirect_valid;
        bus.instruction    = fifo[rd_ptr].data;
        bus.inst_pc        = fifo[rd_ptr].pc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo        <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
        end else if (bus.redirect_valid) begin
            // Everything still in flight becomes stale, minus a response landing right now.
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            fetch_pc    <= {bus.redirect_pc[31:2], 2'b00};
            resp_pc     <= {bus.redirect_pc[31:2], 2'b00};
            outstanding <= outstanding - CW'(bus.imem_rvalid);
            discard     <= outstanding - CW'(bus.imem_rvalid);
        end else begin
            if (issue) fetch_pc <= fetch_pc + 32'd4;
            outstanding <= outstanding + CW'(issue) - CW'(bus.imem_rvalid);
            if (bus.imem_rvalid && discard != '0) discard <= discard - CW'(1);
            if (push) begin
                fifo[wr_ptr] <= '{data: bus.imem_rdata, pc: resp_pc};
                wr_ptr       <= wr_ptr + PW'(1);
                resp_pc      <= resp_pc + 32'd4;
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

`ifdef IFU_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)      fetch_count <= '0;
        else if (pop) fetch_count <= fetch_count + 32'd1;
    end
`endif
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized bench for instruction_fetch_unit: epoch-tagged request model plus latency-pipelined memory.
// Honours IFU_PERF_CNT_EN to also check fetch_count.
module tb_instruction_fetch_unit;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          BUF_DEPTH = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instruction_fetch_unit_if bus();
`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_count;
`endif

    instruction_fetch_unit #(.RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef IFU_PERF_CNT_EN
        ,
        .fetch_count(fetch_count)
`endif
    );

    // Each read carries the redirect epoch it was issued under; replies from older epochs are stale.
    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } rd_t;

    rd_t         inflight[$];
    logic [31:0] exp_fifo[$];
    logic [31:0] m_fetch_pc;
    logic [31:0] m_pops;
    int          epoch, cyc, lat;
    int          n_tests, n_fail;
    bit          prev_rst;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input bit r, input bit rdy, input bit rdyi, input bit redir,
                        input logic [31:0] rpc);
        bit          rv, exp_req;
        rd_t         x;
        logic [31:0] p;
        @(negedge clk);
        rst                = r;
        bus.imem_rdy       = rdy;
        bus.inst_ready     = rdyi;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        rv = !r && inflight.size() > 0 && inflight[0].due <= cyc;
        bus.imem_rvalid    = rv;
        bus.imem_rdata     = rv ? mem_word(inflight[0].addr) : $urandom;
        #1;
        exp_req = !r && !redir && (inflight.size() + exp_fifo.size() < BUF_DEPTH);
        chk("imem_req", 32'(bus.imem_req), 32'(exp_req));
        if (exp_req && bus.imem_req) chk("imem_addr", bus.imem_addr, m_fetch_pc);
        chk("inst_valid", 32'(bus.inst_valid), 32'(exp_fifo.size() != 0));
        if (exp_fifo.size() != 0 && bus.inst_valid) begin
            chk("inst_pc", bus.inst_pc, exp_fifo[0]);
            chk("instruction", bus.instruction, mem_word(exp_fifo[0]));
        end
        if (prev_rst && !r) begin
            chk("rst_instruction", bus.instruction, 32'h0);
            chk("rst_inst_pc", bus.inst_pc, 32'h0);
            chk("rst_imem_addr", bus.imem_addr, RESET_PC);
        end
`ifdef IFU_PERF_CNT_EN
        chk("fetch_count", fetch_count, m_pops);
`endif
        // Advance the reference to what the coming edge should do.
        if (r) begin
            inflight.delete();
            exp_fifo.delete();
            m_fetch_pc = RESET_PC;
            m_pops     = 0;
            epoch++;
        end else if (redir) begin
            if (rv) x = inflight.pop_front();
            exp_fifo.delete();
            epoch++;
            m_fetch_pc = rpc & 32'hFFFF_FFFC;
        end else begin
            if (exp_fifo.size() != 0 && rdyi) begin
                p = exp_fifo.pop_front();
                m_pops++;
            end
            if (rv) begin
                x = inflight.pop_front();
                if (x.epoch == epoch) exp_fifo.push_back(x.addr);
            end
            if (exp_req && rdy) begin
                inflight.push_back('{addr: m_fetch_pc, epoch: epoch, due: cyc + lat});
                m_fetch_pc += 32'd4;
            end
        end
        prev_rst = r;
        cyc++;
    endtask

    task automatic run(input int n, input bit rdy, input bit rdyi);
        for (int i = 0; i < n; i++) step(1'b0, rdy, rdyi, 1'b0, 32'h0);
    endtask

    logic [31:0] targets[3];

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0; epoch = 0; lat = 1;
        m_fetch_pc = RESET_PC; m_pops = 0; prev_rst = 1'b0;
        rst = 1'b1;
        bus.imem_rdy = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
        bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.inst_ready = 1'b0;
        targets[0] = 32'h0000_0103;
        targets[1] = 32'hFFFF_FFF8;
        targets[2] = 32'h0000_0040;

        // Reset, then single-cycle memory with an always-ready consumer.
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        run(30, 1'b1, 1'b1);

        // Consumer stalls: credit must cap outstanding+buffered, data held stable.
        run(10, 1'b1, 1'b0);
        run(10, 1'b1, 1'b1);

        // Three-cycle memory, redirect with reads in flight.
        lat = 3;
        run(4, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0103);
        run(12, 1'b1, 1'b1);

        // Redirect landing on the same edge as a response and a pop.
        lat = 1;
        run(6, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0200);
        run(6, 1'b1, 1'b1);

        // Wrap past the top of the address space.
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
        run(10, 1'b1, 1'b1);

        // Back-to-back redirects: only the last should stick.
        lat = 2;
        run(3, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_1000);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_2002);
        run(8, 1'b1, 1'b1);

        // Random traffic across latencies.
        for (int blk = 0; blk < 8; blk++) begin
            lat = 1 + int'($urandom_range(3));
            for (int i = 0; i < 50; i++) begin
                if ($urandom_range(99) < 6) begin
                    logic [31:0] t;
                    t = ($urandom_range(3) == 3) ? $urandom : targets[$urandom_range(2)];
                    step(1'b0, $urandom_range(3) != 0, $urandom_range(9) < 7, 1'b1, t);
                end else begin
                    step(1'b0, $urandom_range(3) != 0, $urandom_range(9) < 7, 1'b0, 32'h0);
                end
            end
        end

        // Reset mid-stream with a full FIFO.
        lat = 1;
        run(8, 1'b1, 1'b0);
        chk("fifo_full_before_rst", 32'(exp_fifo.size()), 32'(BUF_DEPTH));
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        run(12, 1'b1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
